// File: rtl/awgn_pkg.sv
// awgn_pkg
//   Shared constants and types for the AWGN channel model:
//   - LFSR tap mask for x^32 + x^22 + x^2 + x + 1 (Galois, right-shifting)
//   - offset that centres the four-byte sum around zero
//   - SNR gain table, one entry per 10 dB step (40 dB down to -30 dB)
//   - widths of the noise term and its factors
package awgn_pkg;

  localparam int LFSR_W     = 32;
  localparam int GAIN_W     = 12;
  localparam int NOISE_W    = 23;
  localparam int G_W        = 11;
  localparam int SUM_OFFSET = 510;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  // Entry i is round(10^(i/2)): amplitude gain for a 10 dB SNR step.
  localparam logic [7:0][GAIN_W-1:0] GAIN = {
    12'd3162, 12'd1000, 12'd316, 12'd100,
    12'd32,   12'd10,   12'd3,   12'd1
  };

  // Operands of the noise multiply, registered together in stage 1.
  typedef struct packed {
    logic [G_W-1:0]    g;     // two's complement, -510..+510
    logic [GAIN_W-1:0] gain;  // unsigned
  } noise_term_t;

  function automatic logic [GAIN_W-1:0] gain_lookup(input logic [2:0] idx);
    return GAIN[idx];
  endfunction

endpackage

// File: rtl/awgn_lfsr.sv
// awgn_lfsr
//   32-bit Galois LFSR used as the uniform source for the noise generator.
//   Ports:
//     clk, reset   clock and synchronous active-high reset (state := SEED)
//     advance      step the register once this cycle
//     load         replace the state with load_value (wins over advance)
//     load_value   new state; zero is replaced by 1 to avoid the lock-up state
//     state        current state
module awgn_lfsr
  import awgn_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  output logic [LFSR_W-1:0] state
);

  // An all-zero state would never leave zero, so guard the reset value too.
  localparam logic [LFSR_W-1:0] RESET_STATE = (SEED == '0) ? 32'h1 : SEED;

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_step;
  logic [LFSR_W-1:0] w_load_value;

  assign w_step       = {1'b0, r_state[LFSR_W-1:1]} ^ (r_state[0] ? LFSR_TAPS : '0);
  assign w_load_value = (load_value == '0) ? 32'h1 : load_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else if (load) begin
      r_state <= w_load_value;
    end else if (advance) begin
      r_state <= w_step;
    end
  end

  assign state = r_state;

endmodule

// File: rtl/awgn_channel.sv
// awgn_channel
//   Adds approximately Gaussian noise to a stream of signed samples at a
//   per-sample SNR level, saturating the result. Three-stage pipeline with a
//   single global stall driven by the output handshake.
//   Ports:
//     clk, reset              clock, synchronous active-high reset
//     in_valid / in_ready     input handshake; in_ready is the pipeline enable
//     y, level                clean sample and SNR index captured on accept
//     seed_load, seed         reload the noise LFSR (zero seed becomes 1)
//     out_valid / out_ready   output handshake
//     y_hat                   saturated y + noise
//     noise_debug             sign-extended noise that was added
//     level_err               sticky flag: an out-of-range level was accepted
module awgn_channel
  import awgn_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                NUM_LEVELS = 6,
  parameter logic [LFSR_W-1:0] SEED       = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y,
  input  logic [2:0]        level,
  input  logic              seed_load,
  input  logic [31:0]       seed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y_hat,
  output logic [DATA_W-1:0] noise_debug,
  output logic              level_err
);

  localparam logic [3:0] NUM_LEVELS_U = 4'(NUM_LEVELS);

  // ---------------------------------------------------------------- handshake
  logic w_en;
  logic w_accept;

  logic r_s3_valid;

  assign w_en     = !r_s3_valid || out_ready;
  assign w_accept = in_valid && w_en;
  assign in_ready = w_en;

  // ---------------------------------------------------------- uniform source
  logic [LFSR_W-1:0] w_state;

  awgn_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .advance    (w_accept),
    .load       (seed_load),
    .load_value (seed),
    .state      (w_state)
  );

  // Sum of four uniform bytes: a cheap bell-shaped approximation.
  logic [9:0] w_byte [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign w_byte[gi] = {2'b00, w_state[8*gi +: 8]};
    end
  endgenerate

  logic [9:0]           w_byte_sum;
  logic signed [G_W-1:0] w_g;

  assign w_byte_sum = w_byte[0] + w_byte[1] + w_byte[2] + w_byte[3];
  assign w_g        = $signed({1'b0, w_byte_sum}) - $signed(G_W'(SUM_OFFSET));

  // Out-of-range levels fall back to the smallest gain.
  logic              w_level_ok;
  logic [GAIN_W-1:0] w_gain;

  assign w_level_ok = ({1'b0, level} < NUM_LEVELS_U);
  assign w_gain     = w_level_ok ? gain_lookup(level) : gain_lookup(3'd0);

  // ------------------------------------------------------------------ stage 1
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_y;
  noise_term_t       r_s1_term;
  logic              r_level_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
      r_s1_term  <= '0;
    end else if (w_en) begin
      r_s1_valid     <= w_accept;
      r_s1_y         <= y;
      r_s1_term.g    <= w_g;
      r_s1_term.gain <= w_gain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level_err <= 1'b0;
    end else if (w_accept && !w_level_ok) begin
      r_level_err <= 1'b1;
    end
  end

  // ------------------------------------------------------------------ stage 2
  // |g * gain| <= 510 * 3162 < 2^22, so a NOISE_W-bit product is exact.
  logic signed [NOISE_W-1:0] w_g_ext;
  logic signed [NOISE_W-1:0] w_gain_ext;
  logic signed [NOISE_W-1:0] w_product;

  assign w_g_ext    = {{(NOISE_W-G_W){r_s1_term.g[G_W-1]}}, r_s1_term.g};
  assign w_gain_ext = {{(NOISE_W-GAIN_W){1'b0}}, r_s1_term.gain};
  assign w_product  = w_g_ext * w_gain_ext;

  logic                r_s2_valid;
  logic [DATA_W-1:0]   r_s2_y;
  logic [NOISE_W-1:0]  r_s2_noise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_noise <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_y     <= r_s1_y;
      r_s2_noise <= w_product;
    end
  end

  // ------------------------------------------------------------------ stage 3
  logic [DATA_W-1:0] w_noise_ext;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_sat;

  assign w_noise_ext = {{(DATA_W-NOISE_W){r_s2_noise[NOISE_W-1]}}, r_s2_noise};
  // One guard bit: the top two bits disagree exactly when the sum overflowed.
  assign w_sum = {r_s2_y[DATA_W-1], r_s2_y} + {w_noise_ext[DATA_W-1], w_noise_ext};

  always_comb begin
    w_sat = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      w_sat = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  logic [DATA_W-1:0] r_y_hat;
  logic [DATA_W-1:0] r_noise_debug;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s3_valid    <= 1'b0;
      r_y_hat       <= '0;
      r_noise_debug <= '0;
    end else if (w_en) begin
      r_s3_valid    <= r_s2_valid;
      r_y_hat       <= w_sat;
      r_noise_debug <= w_noise_ext;
    end
  end

  assign out_valid   = r_s3_valid;
  assign y_hat       = r_y_hat;
  assign noise_debug = r_noise_debug;
  assign level_err   = r_level_err;

endmodule

// File: tb/tb_awgn_channel.sv
// tb_awgn_channel
//   Scoreboard bench for awgn_channel: expected outputs are computed from an
//   independent LFSR/noise model when a sample is accepted and compared, in
//   order, when the DUT presents them.
module tb_awgn_channel;

  localparam int          DATA_W     = 32;
  localparam int          NUM_LEVELS = 6;
  localparam logic [31:0] SEED       = 32'h0000_0001;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] y;
  logic [2:0]        level;
  logic              seed_load;
  logic [31:0]       seed;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] y_hat;
  logic [DATA_W-1:0] noise_debug;
  logic              level_err;

  awgn_channel #(
    .DATA_W     (DATA_W),
    .NUM_LEVELS (NUM_LEVELS),
    .SEED       (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .y           (y),
    .level       (level),
    .seed_load   (seed_load),
    .seed        (seed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y_hat       (y_hat),
    .noise_debug (noise_debug),
    .level_err   (level_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    end
  endtask

  // ------------------------------------------------------------------ model
  typedef struct {
    logic [31:0] y_hat;
    logic [31:0] noise;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_state;
  bit          m_level_err;

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] sh;
    sh = s >> 1;
    if (s[0]) sh = sh ^ 32'h8020_0003;
    return sh;
  endfunction

  function automatic int m_gain(input int lvl);
    int l;
    l = (lvl < NUM_LEVELS) ? lvl : 0;
    case (l)
      0: return 1;
      1: return 3;
      2: return 10;
      3: return 32;
      4: return 100;
      5: return 316;
      6: return 1000;
      default: return 3162;
    endcase
  endfunction

  function automatic int m_noise(input logic [31:0] s, input int lvl);
    int g;
    g = int'(s[7:0]) + int'(s[15:8]) + int'(s[23:16]) + int'(s[31:24]) - 510;
    return g * m_gain(lvl);
  endfunction

  function automatic logic [31:0] m_sat(input logic [31:0] yv, input int n);
    longint s;
    s = longint'($signed(yv)) + longint'(n);
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
  endfunction

  // ----------------------------------------------------------------- driver
  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    sb.delete();
    m_state     = SEED;
    m_level_err = 1'b0;
    #1 reset = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] sv);
    seed_load = 1'b1;
    seed      = sv;
    @(negedge clk);
    m_state = (sv == 32'h0) ? 32'h1 : sv;
    @(posedge clk);
    #1 seed_load = 1'b0;
  endtask

  // Drives one sample (optionally with a same-cycle seed load) until accepted.
  // With use_const the expected values are the given constants rather than
  // the model's.
  task automatic send(input logic [31:0] yv, input logic [2:0] lv,
                      input bit with_load, input logic [31:0] sv,
                      input bit use_const, input logic [31:0] cy, input logic [31:0] cn);
    exp_t e;
    int   nz;
    bit   done;
    done      = 1'b0;
    y         = yv;
    level     = lv;
    seed      = sv;
    seed_load = with_load;
    in_valid  = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        nz      = m_noise(m_state, int'(lv));
        e.noise = nz;
        e.y_hat = m_sat(yv, nz);
        if (use_const) begin
          e.y_hat = cy;
          e.noise = cn;
        end
        sb.push_back(e);
        if (int'(lv) >= NUM_LEVELS) m_level_err = 1'b1;
        done = 1'b1;
      end
      if (seed_load)  m_state = (sv == 32'h0) ? 32'h1 : sv;
      else if (done)  m_state = m_step(m_state);
      @(posedge clk);
      #1 seed_load = 1'b0;
    end
    in_valid = 1'b0;
    if (!done) check_val("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    #1;
    check_val("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic stall_pattern(input int cycles, input bit random_mode);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (random_mode) out_ready = ($urandom_range(0, 3) != 0);
      else             out_ready = !(k >= 2 && k < 7);
    end
    out_ready = 1'b1;
  endtask

  // ---------------------------------------------------------------- monitor
  logic [31:0] held_yhat;
  logic [31:0] held_noise;
  bit          holding = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      holding = 1'b0;
    end else begin
      if (holding) begin
        check_val("stall_out_valid", 64'(out_valid), 64'd1);
        check_val("stall_hold_yhat", 64'(y_hat), 64'(held_yhat));
        check_val("stall_hold_noise", 64'(noise_debug), 64'(held_noise));
      end
      if (out_valid && !out_ready)
        check_val("in_ready_stalled", 64'(in_ready), 64'd0);
      holding    = out_valid && !out_ready;
      held_yhat  = y_hat;
      held_noise = noise_debug;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_output", 64'(y_hat), 64'hDEAD_0000_0000);
        end else begin
          e = sb.pop_front();
          $display("out: y_hat=%0d noise=%0d", $signed(y_hat), $signed(noise_debug));
          check_val("y_hat", 64'(y_hat), 64'(e.y_hat));
          check_val("noise_debug", 64'(noise_debug), 64'(e.noise));
        end
      end
    end
  end

  // ------------------------------------------------------------------- main
  initial begin
    y         = '0;
    level     = '0;
    seed      = '0;
    m_state   = SEED;
    do_reset();

    // Reset state
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_y_hat", 64'(y_hat), 64'd0);
    check_val("rst_noise", 64'(noise_debug), 64'd0);
    check_val("rst_level_err", 64'(level_err), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // First sample after reset, with latency check
    send(32'd1000, 3'd0, 1'b0, 32'h0, 1'b1, 32'd491, -32'sd509);
    @(negedge clk); check_val("lat_c1", 64'(out_valid), 64'd0);
    @(negedge clk); check_val("lat_c2", 64'(out_valid), 64'd0);
    @(negedge clk); check_val("lat_c3", 64'(out_valid), 64'd1);
    drain();

    // Same LFSR state, top usable level
    do_reset();
    send(32'd0, 3'd5, 1'b0, 32'h0, 1'b1, -32'sd160844, -32'sd160844);
    drain();

    // Positive saturation
    load_seed(32'hFFFF_FFFF);
    send(32'h7FFF_FFF0, 3'd5, 1'b0, 32'h0, 1'b1, 32'h7FFF_FFFF, 32'd161160);
    drain();

    // Negative saturation (model-driven)
    send(32'h8000_0010, 3'd5, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    drain();

    // Zero seed maps to 1 and reproduces the first noise value
    load_seed(32'h0);
    send(32'd1000, 3'd0, 1'b0, 32'h0, 1'b1, 32'd491, -32'sd509);
    drain();

    // Seed load concurrent with accept: the accepted sample uses the old state
    send(32'd123, 3'd1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
    send(32'd0, 3'd2, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    drain();

    // Eight-sample stream with a five-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, 3'($urandom_range(0, 5)), 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      end
      stall_pattern(12, 1'b0);
    join
    drain();

    // Out-of-range level: gain 1, sticky error until reset
    send(32'd500, 3'd6, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check_val("level_err_set", 64'(level_err), 64'd1);
    @(posedge clk); #1;
    send(32'd0, 3'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    drain();
    check_val("level_err_sticky", 64'(level_err), 64'd1);
    do_reset();
    check_val("level_err_cleared", 64'(level_err), 64'd0);

    // Random stream with random backpressure and all level values
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send($urandom, 3'($urandom_range(0, 7)), 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      stall_pattern(120, 1'b1);
    join
    drain();
    check_val("level_err_random", 64'(level_err), 64'(m_level_err));

    // Reset mid-stream discards in-flight samples
    send(32'd1, 3'd1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    send(32'd2, 3'd2, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    do_reset();
    repeat (6) @(negedge clk);
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(32'd1000, 3'd0, 1'b0, 32'h0, 1'b1, 32'd491, -32'sd509);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/awgn_channel.md
# awgn_channel

Parametrised additive-white-Gaussian-noise channel model for the lab signal path. It replaces the fixed six-way SNR mux with a single pipelined noise generator and a gain table. It adds per-sample noise at a runtime-selected SNR level, with saturation, valid/ready flow control and a reloadable seed. It sits between the transmit-side sample source and the receiver/decoder under test.

## Interface
Parameters:
- DATA_W, 32, sample width, signed two's complement; legal range ≥ 24.
- NUM_LEVELS, 6, number of usable SNR levels (1..8); level i = (40 − 10·i) dB.
- SEED, 32'h0000_0001, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- y  in  DATA_W  clean input sample, signed.
- level  in  3  SNR level index, sampled with each accepted sample.
- seed_load  in  1  load the LFSR from seed this cycle.
- seed  in  32  new LFSR state; 0 is replaced by 32'h1.
- out_valid  out  1  y_hat/noise_debug valid.
- out_ready  in  1  downstream accepts output.
- y_hat  out  DATA_W  saturated y + noise.
- noise_debug  out  DATA_W  sign-extended noise added to this sample.
- level_err  out  1  sticky: an out-of-range level was accepted.

## Operation
- Accept: in_valid && in_ready.
- Uniform source: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. It advances one step per accepted sample only, so the noise sequence is deterministic per sample.
- Gaussian approximation: bytes b0..b3 = state[7:0]..state[31:24]. g = (b0+b1+b2+b3) − 510, signed 11-bit, range −510..+510.
- The current (pre-advance) LFSR state is used for the accepted sample.
- Gain table GAIN[0..7] = 1, 3, 10, 32, 100, 316, 1000, 3162 (12-bit unsigned).
- noise = g · GAIN[level], signed 23-bit, sign-extended to DATA_W.
- If level ≥ NUM_LEVELS, the sample uses GAIN[0] and level_err sets. level_err clears only on reset.
- y_hat = y + noise, saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; it never wraps.
- Seed load: seed_load sets LFSR := (seed==0 ? 1 : seed) and takes priority over the accept-advance.
- A sample accepted in the same cycle as seed_load still uses the old state.

## Timing
- Three-stage pipeline:
  - S1 registers y, the level-resolved gain and g.
  - S2 registers the product.
  - S3 registers the saturated sum, y_hat and noise_debug.
- Latency: 3 cycles from accept to out_valid when out_ready stays high. Throughput: 1 sample/cycle.
- Global stall: en = !out_valid || out_ready, and in_ready = en.
  - While stalled, every stage and the LFSR hold, and y_hat/noise_debug stay stable.
- Pipeline bubbles propagate as per-stage valid bits. out_valid reflects the S3 valid bit.
- Level is captured per sample, so changing level mid-stream affects only samples accepted after the change.
- Reset: all stage valids 0, out_valid 0, y_hat 0, noise_debug 0, level_err 0, LFSR = SEED.
  - in_ready is 1 on the first cycle after reset.
  - Reset mid-stream discards all in-flight samples.
- Simultaneous out_ready and new accept while full: the output is consumed and the pipe advances in the same cycle with no bubble.

## Structure
- Package awgn_pkg holds:
  - GAIN table (8 × 12-bit);
  - LFSR tap mask 32'h8020_0003;
  - SUM_OFFSET = 510;
  - NOISE_W = 23 and GAIN_W = 12.
- Sub-module awgn_lfsr: 32-bit Galois LFSR with advance, load and seed-zero guard. It exposes its current state.
- The top level holds the pipeline, the saturation logic and the handshake.

## Test plan
- Reset, SEED=1, level=0, y=1000 accepted → after 3 cycles y_hat=491, noise_debug=−509, out_valid=1.
- Same state, level=5, y=0 → noise_debug=−160844, y_hat=−160844.
- seed_load with seed=32'hFFFF_FFFF, then level=5, y=32'h7FFF_FFF0 → noise=+161160, y_hat=32'h7FFF_FFFF (saturated).
- Stream 8 samples with out_ready low for 5 cycles mid-stream → in_ready low while full, outputs held stable, no sample lost or duplicated, order preserved.
- level=6 with NUM_LEVELS=6 → GAIN 1 applied, level_err=1 and remains 1 after later legal levels until reset.
- seed_load with seed=0 → LFSR state becomes 1; the next sample reproduces the −509 noise value.
